// File: rtl/jtcps1_vram_arb.sv
// CPS1 video DMA arbiter: shares the VRAM read port among four fetchers and runs the CPU BR/BG handshake.
// Optional bus-grant watchdog is built when JTCPS1_VRAM_ARB_WDOG_EN is defined.
module jtcps1_vram_arb #(
    parameter int AW   = 17,
    parameter int WDOG = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [4*AW-1:0] req_addr,
    output logic [15:0]   rd_data,
    output logic [3:0]    rd_ok,
    output logic          br,
    input  logic          bg,
    output logic [AW-1:0] vram_addr,
    output logic          vram_cs,
    input  logic [15:0]   vram_data,
    input  logic          vram_ok,
    output logic          rfsh_en,
    output logic          wdog_err
);

    typedef enum logic [2:0] {IDLE, BUSREQ, SELECT, READ, RELEASE} state_t;

    state_t        state_q;
    logic          br_q, cs_q, rfsh_q, first_q, retry_q;
    logic [1:0]    idx_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   data_q;
    logic [3:0]    ok_q;
    logic [1:0]    win_d;
    logic [AW-1:0] win_addr_d;

    // Fixed priority: lowest index wins.
    always_comb begin
        win_d = 2'd0;
        for (int n = 3; n >= 0; n--) begin
            if (req[n]) win_d = 2'(n);
        end
        win_addr_d = req_addr[win_d*AW +: AW];
    end

`ifdef JTCPS1_VRAM_ARB_WDOG_EN
    localparam int CW = $clog2(WDOG + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic          wdog_hit;

    assign wdog_hit = (state_q == BUSREQ) && !bg && (cnt_q == CW'(WDOG - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == BUSREQ && !bg) ? cnt_q + 1'b1 : '0;
            if (wdog_hit) err_q <= 1'b1;
        end
    end
    assign wdog_err = err_q;
`else
    logic wdog_hit;
    logic unused_wdog;
    assign wdog_hit    = 1'b0;
    assign unused_wdog = (WDOG == 0);
    assign wdog_err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            br_q    <= 1'b0;
            cs_q    <= 1'b0;
            rfsh_q  <= 1'b1;
            first_q <= 1'b0;
            retry_q <= 1'b0;
            idx_q   <= 2'd0;
            addr_q  <= '0;
            data_q  <= '0;
            ok_q    <= '0;
        end else begin
            ok_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= BUSREQ;
                        br_q    <= 1'b1;
                        rfsh_q  <= 1'b0;
                    end
                end
                BUSREQ: begin
                    if (bg) begin
                        state_q <= SELECT;
                    end else if (wdog_hit) begin
                        br_q    <= 1'b0;
                        state_q <= RELEASE;
                    end
                end
                SELECT: begin
                    // A read aborted by grant loss is reissued before re-arbitrating.
                    if (retry_q && req[idx_q]) begin
                        cs_q    <= 1'b1;
                        first_q <= 1'b1;
                        retry_q <= 1'b0;
                        state_q <= READ;
                    end else if (|req) begin
                        idx_q   <= win_d;
                        addr_q  <= win_addr_d;
                        cs_q    <= 1'b1;
                        first_q <= 1'b1;
                        retry_q <= 1'b0;
                        state_q <= READ;
                    end else begin
                        br_q    <= 1'b0;
                        retry_q <= 1'b0;
                        state_q <= RELEASE;
                    end
                end
                READ: begin
                    if (!bg) begin
                        cs_q    <= 1'b0;
                        retry_q <= 1'b1;
                        state_q <= BUSREQ;
                    end else if (first_q) begin
                        first_q <= 1'b0;
                    end else if (vram_ok) begin
                        cs_q    <= 1'b0;
                        state_q <= SELECT;
                        if (req[idx_q]) begin
                            data_q      <= vram_data;
                            ok_q[idx_q] <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    if (!bg) begin
                        state_q <= IDLE;
                        rfsh_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gating with bg lets the strobe fall in the same cycle the grant goes away.
    assign vram_cs   = cs_q & bg;
    assign vram_addr = addr_q;
    assign br        = br_q;
    assign rd_data   = data_q;
    assign rd_ok     = ok_q;
    assign rfsh_en   = rfsh_q;

endmodule

// File: tb/tb_jtcps1_vram_arb.sv
// Directed bench for jtcps1_vram_arb: BG and VRAM responders plus a pulse monitor.
// Watchdog section is active when JTCPS1_VRAM_ARB_WDOG_EN is defined.
module tb_jtcps1_vram_arb;
    localparam int AW = 17;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      req = 4'b0;
    logic [4*AW-1:0] req_addr = '0;
    logic [15:0]     rd_data;
    logic [3:0]      rd_ok;
    logic            br;
    logic            bg = 1'b0;
    logic [AW-1:0]   vram_addr;
    logic            vram_cs;
    logic [15:0]     vram_data;
    logic            vram_ok = 1'b0;
    logic            rfsh_en;
    logic            wdog_err;

    jtcps1_vram_arb #(.AW(AW), .WDOG(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
        .rd_data(rd_data), .rd_ok(rd_ok), .br(br), .bg(bg),
        .vram_addr(vram_addr), .vram_cs(vram_cs), .vram_data(vram_data),
        .vram_ok(vram_ok), .rfsh_en(rfsh_en), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    assign vram_data = vram_addr[15:0] ^ 16'hA5C3;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_addr(input int n, input logic [AW-1:0] a);
        req_addr[n*AW +: AW] = a;
    endtask

    // bg_mode: 0 low, 1 high, 2 follow br after bg_dly cycles
    int bg_mode = 0, bg_dly = 0, ok_lat = 100, br_cnt = 0, cs_cnt = 0;
    bit ok_always = 1'b0;

    always begin
        @(posedge clk);
        #2;
        cs_cnt  = vram_cs ? cs_cnt + 1 : 0;
        vram_ok = ok_always || (cs_cnt > ok_lat);
        br_cnt  = br ? br_cnt + 1 : 0;
        case (bg_mode)
            0:       bg = 1'b0;
            1:       bg = 1'b1;
            default: bg = (br_cnt > bg_dly);
        endcase
    end

    int pulses = 0, short_err = 0, multi_err = 0, run = 0, last_run = 0;
    logic [3:0]  ok_log[$];
    logic [15:0] dat_log[$];

    always @(negedge clk) begin
        if (vram_cs) run++;
        else begin
            if (run != 0) last_run = run;
            run = 0;
        end
        if (rd_ok != 4'b0) begin
            pulses++;
            ok_log.push_back(rd_ok);
            dat_log.push_back(rd_data);
            if (last_run < 2) short_err++;
            if (!$onehot(rd_ok)) multi_err++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, n0, nbr;
        bit raised;
        logic [3:0]  exp_ok[3];
        logic [15:0] exp_d[3];
        exp_ok = '{4'b0010, 4'b0001, 4'b1000};
        exp_d  = '{16'hA4C3, 16'hA593, 16'hA6C3};

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_br", 32'(br), 0);
        chk("rst_cs", 32'(vram_cs), 0);
        chk("rst_addr", 32'(vram_addr), 0);
        chk("rst_data", 32'(rd_data), 0);
        chk("rst_ok", 32'(rd_ok), 0);
        chk("rst_rfsh", 32'(rfsh_en), 1);
        chk("rst_wdog", 32'(wdog_err), 0);
        rst = 1'b0;
        @(negedge clk);

        // single palette read
        bg_mode = 2; bg_dly = 4; ok_lat = 3;
        set_addr(2, 17'h0910); req = 4'b0100; p0 = pulses;
        @(negedge clk);
        chk("t1_br", 32'(br), 1);
        chk("t1_rfsh", 32'(rfsh_en), 0);
        for (int i = 0; i < 40 && !vram_cs; i++) @(negedge clk);
        chk("t1_cs", 32'(vram_cs), 1);
        chk("t1_addr", 32'(vram_addr), 32'h0910);
        for (int i = 0; i < 40 && rd_ok == 4'b0; i++) @(negedge clk);
        chk("t1_ok", 32'(rd_ok), 32'b0100);
        chk("t1_data", 32'(rd_data), 32'hACD3);
        req = 4'b0;
        for (int i = 0; i < 40 && !rfsh_en; i++) @(negedge clk);
        chk("t1_rfsh_up", 32'(rfsh_en), 1);
        chk("t1_br_low", 32'(br), 0);
        chk("t1_bg_low", 32'(bg), 0);
        chk("t1_hold", 32'(rd_data), 32'hACD3);
        chk("t1_pulses", 32'(pulses - p0), 1);

        // priority: tile and object together, row-scroll arrives during tile read
        bg_dly = 1; ok_lat = 2;
        set_addr(0, 17'h0050); set_addr(1, 17'h0100); set_addr(3, 17'h0300);
        req = 4'b1010; raised = 1'b0; n0 = ok_log.size();
        for (int i = 0; i < 200 && (!raised || req != 4'b0); i++) begin
            @(negedge clk);
            if (vram_cs && vram_addr == 17'h0100 && !raised) begin
                req[0] = 1'b1;
                raised = 1'b1;
            end
            req = req & ~rd_ok;
        end
        repeat (2) @(negedge clk);
        chk("pr_cnt", 32'(ok_log.size() - n0), 3);
        for (int k = 0; k < 3; k++) begin
            chk("pr_ok", 32'((n0 + k < ok_log.size()) ? ok_log[n0 + k] : 4'hF), 32'(exp_ok[k]));
            chk("pr_data", 32'((n0 + k < dat_log.size()) ? dat_log[n0 + k] : 16'hFFFF), 32'(exp_d[k]));
        end
        for (int i = 0; i < 40 && !rfsh_en; i++) @(negedge clk);
        chk("pr_idle", 32'(rfsh_en), 1);

        // stale vram_ok held high, back-to-back words
        bg_mode = 1; ok_always = 1'b1;
        set_addr(0, 17'h0222); set_addr(1, 17'h0333); req = 4'b0011;
        for (int i = 0; i < 40 && !vram_cs; i++) @(negedge clk);
        chk("st_cs", 32'(vram_cs), 1);
        chk("st_first", 32'(rd_ok), 0);
        @(negedge clk);
        chk("st_second", 32'(rd_ok), 0);
        @(negedge clk);
        chk("st_ok", 32'(rd_ok), 32'b0001);
        chk("st_data", 32'(rd_data), 32'hA7E1);
        chk("st_dead", 32'(vram_cs), 0);
        req[0] = 1'b0;
        @(negedge clk);
        chk("st_b2b", 32'(vram_cs), 1);
        chk("st_addr", 32'(vram_addr), 32'h0333);
        for (int i = 0; i < 40 && rd_ok == 4'b0; i++) @(negedge clk);
        chk("st_ok2", 32'(rd_ok), 32'b0010);
        chk("st_data2", 32'(rd_data), 32'hA6F0);
        req = 4'b0;
        for (int i = 0; i < 40 && br; i++) @(negedge clk);
        ok_always = 1'b0; bg_mode = 0;
        for (int i = 0; i < 40 && !rfsh_en; i++) @(negedge clk);
        chk("st_idle", 32'(rfsh_en), 1);

        // requester withdraws mid-read
        bg_mode = 1; ok_lat = 3;
        set_addr(3, 17'h0444); req = 4'b1000; p0 = pulses;
        for (int i = 0; i < 40 && !vram_cs; i++) @(negedge clk);
        req = 4'b0;
        for (int i = 0; i < 40 && vram_cs; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("wd_no_ok", 32'(pulses - p0), 0);
        chk("wd_br", 32'(br), 0);
        chk("wd_hold", 32'(rd_data), 32'hA6F0);
        bg_mode = 0;
        for (int i = 0; i < 40 && !rfsh_en; i++) @(negedge clk);

        // grant lost during object read
        bg_mode = 1; ok_lat = 100;
        set_addr(3, 17'h1F00); req = 4'b1000; p0 = pulses;
        for (int i = 0; i < 40 && !vram_cs; i++) @(negedge clk);
        chk("gl_addr", 32'(vram_addr), 32'h1F00);
        bg_mode = 0;
        @(posedge clk); #3;
        chk("gl_cs_same", 32'(vram_cs), 0);
        @(negedge clk);
        chk("gl_br", 32'(br), 1);
        repeat (3) @(negedge clk);
        chk("gl_no_ok", 32'(pulses - p0), 0);
        ok_lat = 2; bg_mode = 1;
        for (int i = 0; i < 40 && !vram_cs; i++) @(negedge clk);
        chk("gl_readdr", 32'(vram_addr), 32'h1F00);
        for (int i = 0; i < 40 && rd_ok == 4'b0; i++) @(negedge clk);
        chk("gl_ok", 32'(rd_ok), 32'b1000);
        chk("gl_data", 32'(rd_data), 32'hBAC3);
        req = 4'b0;
        repeat (2) @(negedge clk);
        chk("gl_pulses", 32'(pulses - p0), 1);
        bg_mode = 0;
        for (int i = 0; i < 40 && !rfsh_en; i++) @(negedge clk);

        // asynchronous reset mid-read
        bg_mode = 1; ok_lat = 100;
        set_addr(1, 17'h0555); req = 4'b0010;
        for (int i = 0; i < 40 && !vram_cs; i++) @(negedge clk);
        chk("rr_cs", 32'(vram_cs), 1);
        #2 rst = 1'b1;
        #1;
        chk("rr_br", 32'(br), 0);
        chk("rr_cs0", 32'(vram_cs), 0);
        chk("rr_ok", 32'(rd_ok), 0);
        chk("rr_rfsh", 32'(rfsh_en), 1);
        chk("rr_data", 32'(rd_data), 0);
        req = 4'b0; bg_mode = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rr_idle", 32'(rfsh_en), 1);
        chk("rr_br_low", 32'(br), 0);

`ifdef JTCPS1_VRAM_ARB_WDOG_EN
        bg_mode = 0; nbr = 0;
        set_addr(0, 17'h0123); req = 4'b0001;
        for (int i = 0; i < 100 && !wdog_err; i++) begin
            @(negedge clk);
            if (br) nbr++;
        end
        chk("wg_err", 32'(wdog_err), 1);
        chk("wg_cycles", 32'(nbr), 16);
        chk("wg_br", 32'(br), 0);
        req = 4'b0;
        repeat (4) @(negedge clk);
        chk("wg_sticky", 32'(wdog_err), 1);
        rst = 1'b1;
        #1;
        chk("wg_clear", 32'(wdog_err), 0);
        @(negedge clk);
        rst = 1'b0;
`else
        nbr = 0;
        chk("wdog_off", 32'(wdog_err + nbr), 0);
`endif

        @(negedge clk);
        chk("short_reads", 32'(short_err), 0);
        chk("onehot_ok", 32'(multi_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
